voice_mixer: RTL and testbench

Upstream producer for the codec sample conditioner. On each `generate_next_sample` pulse it fetches one sample per voice from the voice bank over a req/ack handshake, pans and accumulates each into left/right sums, saturates to 16 bits, and presents left, right and mono samples with a one-cycle `latch_new_sample_in` strobe. Its outputs connect directly to `new_sample_in_left`, `new_sample_in_right`, `new_sample_in` and `latch_new_sample_in` of the conditioner.

---
 rtl/voice_mixer_pkg.sv | 33 +++
 rtl/voice_mixer_pan_mac.sv | 82 ++++++++
 rtl/voice_mixer.sv | 168 ++++++++++++++++
 tb/tb_voice_mixer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/voice_mixer_pkg.sv
// Shared types, constants and the output saturation helper for voice_mixer.
package voice_mixer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_MAC  = 2'd2,
      ST_SAT  = 2'd3
   } state_t;

   localparam int ACC_W    = 20;
   localparam int SAMPLE_W = 16;
   localparam int PROD_W   = 21;
   localparam int TERM_W   = 17;

   localparam logic [3:0]               PAN_MAX    = 4'd15;
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

   // Clamp a wide accumulator into the signed 16-bit sample range.
   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
      logic signed [SAMPLE_W-1:0] r;
      if (a > ACC_W'(SAMPLE_MAX)) begin
         r = SAMPLE_MAX;
      end else if (a < ACC_W'(SAMPLE_MIN)) begin
         r = SAMPLE_MIN;
      end else begin
         r = a[SAMPLE_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/voice_mixer_pan_mac.sv
// Pan/multiply/accumulate datapath: captures one voice sample and pan value,
// splits it into left/right gains and accumulates the scaled products.
module voice_mixer_pan_mac
   import voice_mixer_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     cap_en,
   input  logic                     acc_en,
   input  logic [SAMPLE_W-1:0]      sample_in,
   input  logic [3:0]               pan_in,
   output logic signed [ACC_W-1:0]  acc_l,
   output logic signed [ACC_W-1:0]  acc_r
);

   logic signed [SAMPLE_W-1:0] sample_q, sample_d;
   logic [3:0]                 pan_q, pan_d;
   logic signed [ACC_W-1:0]    acc_l_q, acc_l_d;
   logic signed [ACC_W-1:0]    acc_r_q, acc_r_d;

   logic signed [4:0]          gain_l_s;
   logic signed [4:0]          gain_r_s;
   logic signed [PROD_W-1:0]   prod_l_s;
   logic signed [PROD_W-1:0]   prod_r_s;
   logic signed [TERM_W-1:0]   term_l_s;
   logic signed [TERM_W-1:0]   term_r_s;

   // Next-state logic: capture on ack, clear per frame, accumulate floor-scaled terms.
   always_comb begin
      gain_l_s = $signed({1'b0, PAN_MAX - pan_q});
      gain_r_s = $signed({1'b0, pan_q});
      prod_l_s = PROD_W'(sample_q) * PROD_W'(gain_l_s);
      prod_r_s = PROD_W'(sample_q) * PROD_W'(gain_r_s);
      // Arithmetic shift floors toward minus infinity; the /16 result fits 17 bits.
      term_l_s = TERM_W'(prod_l_s >>> 4);
      term_r_s = TERM_W'(prod_r_s >>> 4);

      sample_d = sample_q;
      pan_d    = pan_q;
      acc_l_d  = acc_l_q;
      acc_r_d  = acc_r_q;

      if (cap_en) begin
         sample_d = sample_in;
         pan_d    = pan_in;
      end else begin
         sample_d = sample_q;
         pan_d    = pan_q;
      end

      if (clr) begin
         acc_l_d = {ACC_W{1'b0}};
         acc_r_d = {ACC_W{1'b0}};
      end else if (acc_en) begin
         acc_l_d = acc_l_q + ACC_W'(term_l_s);
         acc_r_d = acc_r_q + ACC_W'(term_r_s);
      end else begin
         acc_l_d = acc_l_q;
         acc_r_d = acc_r_q;
      end
   end

   // Datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sample_q <= 16'sd0;
         pan_q    <= 4'd0;
         acc_l_q  <= 20'sd0;
         acc_r_q  <= 20'sd0;
      end else begin
         sample_q <= sample_d;
         pan_q    <= pan_d;
         acc_l_q  <= acc_l_d;
         acc_r_q  <= acc_r_d;
      end
   end

   assign acc_l = acc_l_q;
   assign acc_r = acc_r_q;

endmodule

// File: rtl/voice_mixer.sv
// Frame sequencer for the voice mixer: fetches each voice over req/ack,
// drives the pan MAC, then saturates and presents left/right/mono samples.
module voice_mixer
   import voice_mixer_pkg::*;
#(
   parameter int NUM_VOICES  = 4,
   parameter int VOICE_IDX_W = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   generate_next_sample,
   output logic                   voice_req,
   output logic [VOICE_IDX_W-1:0] voice_sel,
   input  logic                   voice_ack,
   input  logic [SAMPLE_W-1:0]    voice_sample,
   input  logic [3:0]             voice_pan,
   output logic [SAMPLE_W-1:0]    new_sample_left,
   output logic [SAMPLE_W-1:0]    new_sample_right,
   output logic [SAMPLE_W-1:0]    new_sample_mono,
   output logic                   latch_new_sample,
   output logic                   busy,
   output logic                   overrun,
   input  logic                   overrun_clr
);

   localparam logic [VOICE_IDX_W-1:0] LAST_IDX = VOICE_IDX_W'(NUM_VOICES - 1);

   state_t                     state_q, state_d;
   logic [VOICE_IDX_W-1:0]     idx_q, idx_d;
   logic                       voice_req_q, voice_req_d;
   logic [VOICE_IDX_W-1:0]     voice_sel_q, voice_sel_d;
   logic signed [SAMPLE_W-1:0] left_q, left_d;
   logic signed [SAMPLE_W-1:0] right_q, right_d;
   logic signed [SAMPLE_W-1:0] mono_q, mono_d;
   logic                       latch_q, latch_d;
   logic                       busy_q, busy_d;
   logic                       overrun_q, overrun_d;

   logic                       clr_s;
   logic                       cap_en_s;
   logic                       acc_en_s;
   logic signed [ACC_W-1:0]    acc_l_s;
   logic signed [ACC_W-1:0]    acc_r_s;
   logic signed [SAMPLE_W-1:0] sat_l_s;
   logic signed [SAMPLE_W-1:0] sat_r_s;
   logic signed [SAMPLE_W:0]   mono_sum_s;

   voice_mixer_pan_mac u_pan_mac (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr_s),
      .cap_en    (cap_en_s),
      .acc_en    (acc_en_s),
      .sample_in (voice_sample),
      .pan_in    (voice_pan),
      .acc_l     (acc_l_s),
      .acc_r     (acc_r_s)
   );

   // FSM next state, datapath controls, saturation and next output values.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      left_d      = left_q;
      right_d     = right_q;
      mono_d      = mono_q;
      latch_d     = 1'b0;
      overrun_d   = overrun_q;
      clr_s       = 1'b0;
      cap_en_s    = 1'b0;
      acc_en_s    = 1'b0;

      sat_l_s    = sat16(acc_l_s);
      sat_r_s    = sat16(acc_r_s);
      mono_sum_s = (SAMPLE_W+1)'(sat_l_s) + (SAMPLE_W+1)'(sat_r_s);

      case (state_q)
         ST_IDLE: begin
            clr_s = 1'b1;
            idx_d = {VOICE_IDX_W{1'b0}};
            if (generate_next_sample) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (voice_ack) begin
               cap_en_s = 1'b1;
               state_d  = ST_MAC;
            end else begin
               state_d  = ST_REQ;
            end
         end
         ST_MAC: begin
            acc_en_s = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = ST_SAT;
            end else begin
               idx_d   = idx_q + VOICE_IDX_W'(1);
               state_d = ST_REQ;
            end
         end
         ST_SAT: begin
            left_d  = sat_l_s;
            right_d = sat_r_s;
            mono_d  = SAMPLE_W'(mono_sum_s >>> 1);
            latch_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            idx_d   = {VOICE_IDX_W{1'b0}};
            state_d = ST_IDLE;
         end
      endcase

      // Clearing wins over a simultaneous overrun event.
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end else if (generate_next_sample && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      // Handshake outputs are registered copies of the upcoming state/index.
      busy_d      = (state_d != ST_IDLE);
      voice_req_d = (state_d == ST_REQ);
      voice_sel_d = idx_d;
   end

   // Sequencer and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= {VOICE_IDX_W{1'b0}};
         voice_req_q <= 1'b0;
         voice_sel_q <= {VOICE_IDX_W{1'b0}};
         left_q      <= 16'sd0;
         right_q     <= 16'sd0;
         mono_q      <= 16'sd0;
         latch_q     <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         voice_req_q <= voice_req_d;
         voice_sel_q <= voice_sel_d;
         left_q      <= left_d;
         right_q     <= right_d;
         mono_q      <= mono_d;
         latch_q     <= latch_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign voice_req        = voice_req_q;
   assign voice_sel        = voice_sel_q;
   assign new_sample_left  = left_q;
   assign new_sample_right = right_q;
   assign new_sample_mono  = mono_q;
   assign latch_new_sample = latch_q;
   assign busy             = busy_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer with a cycle-accurate voice bank model.
module tb_voice_mixer;

   logic        clk;
   logic        reset;
   logic        generate_next_sample;
   logic        voice_req;
   logic [1:0]  voice_sel;
   logic        voice_ack;
   logic [15:0] voice_sample;
   logic [3:0]  voice_pan;
   logic [15:0] new_sample_left;
   logic [15:0] new_sample_right;
   logic [15:0] new_sample_mono;
   logic        latch_new_sample;
   logic        busy;
   logic        overrun;
   logic        overrun_clr;

   int checks;
   int failures;

   logic [15:0] smp [4];
   logic [3:0]  pn  [4];

   int  fs;
   int  ns;
   bit  stable;
   bit  busy1;

   voice_mixer #(.NUM_VOICES(4), .VOICE_IDX_W(2)) dut (
      .clk                  (clk),
      .reset                (reset),
      .generate_next_sample (generate_next_sample),
      .voice_req            (voice_req),
      .voice_sel            (voice_sel),
      .voice_ack            (voice_ack),
      .voice_sample         (voice_sample),
      .voice_pan            (voice_pan),
      .new_sample_left      (new_sample_left),
      .new_sample_right     (new_sample_right),
      .new_sample_mono      (new_sample_mono),
      .latch_new_sample     (latch_new_sample),
      .busy                 (busy),
      .overrun              (overrun),
      .overrun_clr          (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_voices(input logic [15:0] s0, input logic [3:0] p0,
                             input logic [15:0] s1, input logic [3:0] p1,
                             input logic [15:0] s2, input logic [3:0] p2,
                             input logic [15:0] s3, input logic [3:0] p3);
      smp[0] = s0; pn[0] = p0;
      smp[1] = s1; pn[1] = p1;
      smp[2] = s2; pn[2] = p2;
      smp[3] = s3; pn[3] = p3;
   endtask

   // Runs one frame for 30 cycles, acting as the voice bank; cycle 0 is the request cycle.
   task automatic run_frame(input int wait_voice, input int wait_n, input int ovr_cyc,
                            input int clr_cyc, input int rst_cyc, input bit b2b,
                            output int first_strobe, output int n_strobes,
                            output bit sel_stable, output bit busy_c1);
      int waited;
      bit in_wait;
      @(posedge clk); #1;
      generate_next_sample = 1'b1;
      waited = 0; in_wait = 1'b0;
      first_strobe = -1; n_strobes = 0; sel_stable = 1'b1; busy_c1 = 1'b0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(posedge clk); #1;
         generate_next_sample = 1'b0;
         overrun_clr = 1'b0;
         reset = 1'b1;
         voice_ack = 1'b0;
         if (cyc == 1) busy_c1 = busy;
         if (latch_new_sample === 1'b1) begin
            n_strobes++;
            if (first_strobe < 0) first_strobe = cyc;
            if (b2b && n_strobes == 1) generate_next_sample = 1'b1;
         end
         if (cyc == ovr_cyc) generate_next_sample = 1'b1;
         if (cyc == clr_cyc) overrun_clr = 1'b1;
         if (cyc == rst_cyc) reset = 1'b0;
         if (in_wait && !(voice_req === 1'b1 && int'(voice_sel) == wait_voice))
            sel_stable = 1'b0;
         if (voice_req === 1'b1 && reset) begin
            if (int'(voice_sel) == wait_voice && waited < wait_n) begin
               in_wait = 1'b1;
               waited++;
            end else begin
               voice_ack    = 1'b1;
               voice_sample = smp[voice_sel];
               voice_pan    = pn[voice_sel];
               if (int'(voice_sel) == wait_voice) in_wait = 1'b0;
            end
         end
      end
      voice_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (new_sample_left !== 16'd0) begin failures++; $display("FAIL reset_left got=%0h exp=0", new_sample_left); end
      checks++; if (new_sample_mono !== 16'd0) begin failures++; $display("FAIL reset_mono got=%0h exp=0", new_sample_mono); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (voice_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", voice_req); end
      checks++; if (latch_new_sample !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL reset_strobe_ovr got=%b%b exp=00", latch_new_sample, overrun); end
      reset = 1'b1;
   endtask

   task automatic test_single_voice();
      set_voices(16'h1000, 4'd8, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0, 4'd0);
      run_frame(-1, 0, -1, -1, -1, 1'b0, fs, ns, stable, busy1);
      checks++; if (fs !== 10) begin failures++; $display("FAIL single_strobe_cycle got=%0d exp=10", fs); end
      checks++; if (ns !== 1) begin failures++; $display("FAIL single_strobe_count got=%0d exp=1", ns); end
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL single_busy_c1 got=%b exp=1", busy1); end
      checks++; if (new_sample_left !== 16'd1792) begin failures++; $display("FAIL single_left got=%0d exp=1792", $signed(new_sample_left)); end
      checks++; if (new_sample_right !== 16'd2048) begin failures++; $display("FAIL single_right got=%0d exp=2048", $signed(new_sample_right)); end
      checks++; if (new_sample_mono !== 16'd1920) begin failures++; $display("FAIL single_mono got=%0d exp=1920", $signed(new_sample_mono)); end
   endtask

   // Mixed signs and pans, exercising floor rounding: expected L=516 R=2598 mono=1557.
   task automatic test_mixed(input int wait_n, input int exp_cyc);
      set_voices(16'h1000, 4'd8, -16'sd2000, 4'd3, 16'd1234, 4'd12, -16'sd7, 4'd0);
      run_frame(2, wait_n, -1, -1, -1, 1'b0, fs, ns, stable, busy1);
      checks++; if (fs !== exp_cyc) begin failures++; $display("FAIL mixed_strobe_cycle wait=%0d got=%0d exp=%0d", wait_n, fs, exp_cyc); end
      checks++; if (ns !== 1) begin failures++; $display("FAIL mixed_strobe_count got=%0d exp=1", ns); end
      checks++; if (stable !== 1'b1) begin failures++; $display("FAIL mixed_req_sel_stable got=%b exp=1", stable); end
      checks++; if (new_sample_left !== 16'd516) begin failures++; $display("FAIL mixed_left got=%0d exp=516", $signed(new_sample_left)); end
      checks++; if (new_sample_right !== 16'd2598) begin failures++; $display("FAIL mixed_right got=%0d exp=2598", $signed(new_sample_right)); end
      checks++; if (new_sample_mono !== 16'd1557) begin failures++; $display("FAIL mixed_mono got=%0d exp=1557", $signed(new_sample_mono)); end
   endtask

   task automatic test_saturation();
      set_voices(16'h7FFF, 4'd0, 16'h7FFF, 4'd0, 16'h7FFF, 4'd0, 16'h7FFF, 4'd0);
      run_frame(-1, 0, -1, -1, -1, 1'b0, fs, ns, stable, busy1);
      checks++; if (new_sample_left !== 16'h7FFF) begin failures++; $display("FAIL possat_left got=%0d exp=32767", $signed(new_sample_left)); end
      checks++; if (new_sample_right !== 16'h0000) begin failures++; $display("FAIL possat_right got=%0d exp=0", $signed(new_sample_right)); end
      checks++; if (new_sample_mono !== 16'h3FFF) begin failures++; $display("FAIL possat_mono got=%0d exp=16383", $signed(new_sample_mono)); end
      set_voices(16'h8000, 4'd15, 16'h8000, 4'd15, 16'h8000, 4'd15, 16'h8000, 4'd15);
      run_frame(-1, 0, -1, -1, -1, 1'b0, fs, ns, stable, busy1);
      checks++; if (new_sample_left !== 16'h0000) begin failures++; $display("FAIL negsat_left got=%0d exp=0", $signed(new_sample_left)); end
      checks++; if (new_sample_right !== 16'h8000) begin failures++; $display("FAIL negsat_right got=%0d exp=-32768", $signed(new_sample_right)); end
      checks++; if (new_sample_mono !== 16'hC000) begin failures++; $display("FAIL negsat_mono got=%0d exp=-16384", $signed(new_sample_mono)); end
   endtask

   task automatic test_overrun();
      set_voices(16'h1000, 4'd8, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0, 4'd0);
      run_frame(-1, 0, 4, -1, -1, 1'b0, fs, ns, stable, busy1);
      checks++; if (ns !== 1) begin failures++; $display("FAIL ovr_strobe_count got=%0d exp=1", ns); end
      checks++; if (fs !== 10) begin failures++; $display("FAIL ovr_strobe_cycle got=%0d exp=10", fs); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
      checks++; if (new_sample_left !== 16'd1792) begin failures++; $display("FAIL ovr_left got=%0d exp=1792", $signed(new_sample_left)); end
      // Clear and a busy request in the same cycle: clear wins.
      run_frame(-1, 0, 3, 3, -1, 1'b0, fs, ns, stable, busy1);
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr_priority got=%b exp=0", overrun); end
      run_frame(-1, 0, 4, -1, -1, 1'b0, fs, ns, stable, busy1);
      @(posedge clk); #1;
      overrun_clr = 1'b1;
      @(posedge clk); #1;
      overrun_clr = 1'b0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
   endtask

   task automatic test_back_to_back();
      set_voices(16'h1000, 4'd8, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0, 4'd0);
      run_frame(-1, 0, -1, -1, -1, 1'b1, fs, ns, stable, busy1);
      checks++; if (ns !== 2) begin failures++; $display("FAIL b2b_strobe_count got=%0d exp=2", ns); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
      checks++; if (new_sample_mono !== 16'd1920) begin failures++; $display("FAIL b2b_mono got=%0d exp=1920", $signed(new_sample_mono)); end
   endtask

   task automatic test_reset_midframe();
      set_voices(16'h1000, 4'd8, 16'd0, 4'd0, 16'd0, 4'd0, 16'd0, 4'd0);
      run_frame(-1, 0, -1, -1, 5, 1'b0, fs, ns, stable, busy1);
      checks++; if (ns !== 0) begin failures++; $display("FAIL rstmid_strobe_count got=%0d exp=0", ns); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (new_sample_right !== 16'd0 || new_sample_left !== 16'd0) begin failures++; $display("FAIL rstmid_outputs got=%0h/%0h exp=0/0", new_sample_left, new_sample_right); end
      run_frame(-1, 0, -1, -1, -1, 1'b0, fs, ns, stable, busy1);
      checks++; if (fs !== 10) begin failures++; $display("FAIL rstmid_next_cycle got=%0d exp=10", fs); end
      checks++; if (new_sample_left !== 16'd1792) begin failures++; $display("FAIL rstmid_next_left got=%0d exp=1792", $signed(new_sample_left)); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      generate_next_sample = 1'b0;
      voice_ack = 1'b0;
      voice_sample = 16'd0;
      voice_pan = 4'd0;
      overrun_clr = 1'b0;
      test_reset();
      test_single_voice();
      test_mixed(0, 10);
      test_mixed(3, 13);
      test_saturation();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
